// File: rtl/g_circulant_row_store.sv
// g_circulant_row_store: run-time loadable QC generator row store with per-block circulant rotation on read
module g_circulant_row_store #(
    parameter int CIRC_SIZE = 88,
    parameter int NUM_CIRC  = 16,
    parameter int ROWS      = 39,
    parameter int WORD_W    = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [WORD_W-1:0]                wr_data,
    output logic                             loaded,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [$clog2(ROWS)-1:0]          req_row,
    input  logic [$clog2(CIRC_SIZE)-1:0]     req_shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CIRC*CIRC_SIZE-1:0]    out_data,
    output logic                             out_err
);
    localparam int ROW_W = NUM_CIRC * CIRC_SIZE;
    localparam int WPR   = (ROW_W + WORD_W - 1) / WORD_W;
    localparam int PAD_W = WPR * WORD_W;
    localparam int RAW   = $clog2(ROWS);
    localparam int SW    = $clog2(CIRC_SIZE);
    localparam int WCW   = WPR > 1 ? $clog2(WPR) : 1;

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t           state;
    logic [RAW-1:0]   row_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [PAD_W-1:0] mem [ROWS];
    logic             last_word, last_row, req_err;
    logic [SW-1:0]    sh;
    logic [ROW_W-1:0] row_q, rot;
    logic [2*CIRC_SIZE-1:0] dbl;

    assign wr_ready  = (state == LOAD) && !load_start;
    assign req_ready = (state == READY) && (!out_valid || out_ready) && !load_start;
    assign last_word = word_cnt == WCW'(WPR - 1);
    assign last_row  = row_cnt == RAW'(ROWS - 1);

    always_ff @(posedge clk)
        if (wr_valid && wr_ready) mem[row_cnt][int'(word_cnt)*WORD_W +: WORD_W] <= wr_data;

    // Rotate-left via a doubled block: the upper half of {b,b}<<s is b rotated left by s.
    always_comb begin
        req_err = int'(req_row) >= ROWS || int'(req_shift) >= CIRC_SIZE;
        row_q   = req_err ? '0 : mem[req_row][ROW_W-1:0];
        sh      = req_err ? '0 : req_shift;
        rot     = '0;
        dbl     = '0;
        for (int j = 0; j < NUM_CIRC; j++) begin
            dbl = {row_q[j*CIRC_SIZE +: CIRC_SIZE], row_q[j*CIRC_SIZE +: CIRC_SIZE]} << sh;
            rot[j*CIRC_SIZE +: CIRC_SIZE] = dbl[2*CIRC_SIZE-1:CIRC_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= EMPTY;
            row_cnt   <= '0;
            word_cnt  <= '0;
            loaded    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (load_start) begin
            state     <= LOAD;
            row_cnt   <= '0;
            word_cnt  <= '0;
            loaded    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (wr_valid && wr_ready) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                if (last_word) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                if (last_word && last_row) begin
                    state  <= READY;
                    loaded <= 1'b1;
                end
            end
            if (req_valid && req_ready) begin
                out_valid <= 1'b1;
                out_data  <= rot;
                out_err   <= req_err;
            end else if (out_ready) out_valid <= 1'b0;
        end
endmodule
